// File: rtl/rr_grant_encoder_pkg.sv
// Shared definitions for the round-robin grant encoder.
// - N_DEF / W_DEF : default requester count and encoded index width
// - arb_state_t   : FSM state (IDLE: no live grant, HOLD: grant waiting for ready)
package arb_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = $clog2(N_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_grant_encoder_if.sv
// Request/grant bundle between the requesters/consumer and the arbiter.
// Signals:
//   en    : arbitration enable; when low no new grant is issued
//   req   : request lines, req[i]=1 means requester i wants the resource
//   ready : consumer accepts the current grant this cycle
//   valid : idx/grant hold a live grant
//   idx   : binary index of the granted requester
//   grant : one-hot of idx while valid, otherwise zero
// Handshake: a grant transfers on a rising edge where valid=1 and ready=1.
// While valid=1 and ready=0, idx/grant/valid are held stable. ready is
// ignored while valid=0.
// Modports: slave = arbiter side, master = requester/consumer side.
interface rr_grant_encoder_if #(
  parameter int N = arb_pkg::N_DEF,
  parameter int W = $clog2(N)
) ();

  logic         en;
  logic [N-1:0] req;
  logic         ready;
  logic         valid;
  logic [W-1:0] idx;
  logic [N-1:0] grant;

  modport master (
    output en, req, ready,
    input  valid, idx, grant
  );

  modport slave (
    input  en, req, ready,
    output valid, idx, grant
  );

endinterface

// File: rtl/rr_grant_encoder_pick.sv
// Combinational round-robin pick.
// Ports:
//   req  : request lines
//   ptr  : highest-priority slot (must be < N)
//   pick : first index in order ptr, ptr+1, ..., ptr+N-1 (mod N) with req set
//   any  : at least one request is set (pick is 0 when any=0)
module rr_pick import arb_pkg::*; #(
  parameter int N = N_DEF,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] pick,
  output logic         any
);

  always_comb begin
    pick = '0;
    any  = 1'b0;
    // Walk from lowest to highest priority so the highest-priority hit is
    // written last. The wrap uses an explicit compare so non-power-of-2 N works.
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        pick = W'(j);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter with registered binary index and one-hot grant.
// Ports:
//   clk       : clock, all state updates on rising edge
//   reset_n   : synchronous active-low reset
//   bus       : request/grant bundle (slave side)
//   dbg_state : current FSM state
//   dbg_ptr   : round-robin pointer (highest-priority slot for next pick)
// The pointer moves only when a grant is accepted, to the slot after the
// accepted index, so a requester that keeps asking cannot starve the others.
module rr_grant_encoder import arb_pkg::*; #(
  parameter int N = N_DEF,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  rr_grant_encoder_if.slave bus,
  output arb_state_t   dbg_state,
  output logic [W-1:0] dbg_ptr
);

  arb_state_t   state_q, state_n;
  logic [W-1:0] ptr_q, ptr_n;
  logic [W-1:0] idx_q, idx_n;
  logic         valid_q, valid_n;
  logic [N-1:0] grant_q, grant_n;

  logic         accept;
  logic [W-1:0] ptr_after;
  logic [W-1:0] pick_ptr;
  logic [W-1:0] pick;
  logic         any;

  assign accept    = (state_q == HOLD) && bus.ready;
  assign ptr_after = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
  // On accept a back-to-back pick must already see the advanced pointer.
  assign pick_ptr  = accept ? ptr_after : ptr_q;

  rr_pick #(.N(N), .W(W)) u_pick (
    .req  (bus.req),
    .ptr  (pick_ptr),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    idx_n   = idx_q;
    valid_n = valid_q;
    grant_n = '0;

    case (state_q)
      IDLE: begin
        if (bus.en && any) begin
          idx_n   = pick;
          valid_n = 1'b1;
          state_n = HOLD;
        end else begin
          valid_n = 1'b0;
        end
      end
      HOLD: begin
        if (accept) begin
          ptr_n = ptr_after;
          if (bus.en && any) begin
            idx_n   = pick;
            valid_n = 1'b1;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase

    // Registered one-hot so grant is glitch-free relative to clk.
    for (int i = 0; i < N; i++) begin
      grant_n[i] = valid_n && (idx_n == W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
      grant_q <= grant_n;
    end
  end

  assign bus.valid = valid_q;
  assign bus.idx   = idx_q;
  assign bus.grant = grant_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Bench for rr_grant_encoder: directed vectors with literal expectations plus
// a short random tail, all cross-checked every cycle against a queue-free
// behavioural model of the arbitration rules.
module tb_rr_grant_encoder;
  import arb_pkg::*;

  localparam int N = 4;
  localparam int W = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rr_grant_encoder_if #(.N(N), .W(W)) bus ();
  arb_state_t   dbg_state;
  logic [W-1:0] dbg_ptr;

  rr_grant_encoder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_ptr   = 0;

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
    end else if (m_valid) begin
      if (bus.ready) begin
        m_ptr = (m_idx + 1) % N;
        if (bus.en && bus.req != '0) m_idx = model_pick(bus.req, m_ptr);
        else m_valid = 1'b0;
      end
    end else if (bus.en && bus.req != '0) begin
      m_idx   = model_pick(bus.req, m_ptr);
      m_valid = 1'b1;
    end
  end

  // per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    chk("cyc_valid", {31'd0, bus.valid}, {31'd0, m_valid});
    chk("cyc_grant", {28'd0, bus.grant}, m_valid ? (32'd1 << m_idx) : 32'd0);
    if (m_valid) chk("cyc_idx", {30'd0, bus.idx}, m_idx);
    chk("cyc_ptr", {30'd0, dbg_ptr}, m_ptr);
    chk("cyc_state", {31'd0, dbg_state == HOLD}, {31'd0, m_valid});
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [W-1:0] i,
                            input logic [N-1:0] g);
    chk({name, "_valid"}, {31'd0, bus.valid}, {31'd0, v});
    chk({name, "_grant"}, {28'd0, bus.grant}, {28'd0, g});
    if (v) chk({name, "_idx"}, {30'd0, bus.idx}, {30'd0, i});
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.req   = 4'b1111;
    bus.en    = 1'b1;
    bus.ready = 1'b0;

    // reset holds everything off despite requests
    step(); expect_out("rst0", 1'b0, 2'd0, 4'b0000); chk("rst0_idx", {30'd0, bus.idx}, 0);
    step(); expect_out("rst1", 1'b0, 2'd0, 4'b0000); chk("rst1_idx", {30'd0, bus.idx}, 0);

    // single request, sticky hold, accept
    reset_n = 1'b1; bus.req = 4'b0100;
    step(); expect_out("single", 1'b1, 2'd2, 4'b0100);
    bus.req = 4'b0000;
    repeat (5) begin step(); expect_out("hold", 1'b1, 2'd2, 4'b0100); end
    bus.ready = 1'b1;
    step(); expect_out("accept", 1'b0, 2'd0, 4'b0000); chk("accept_ptr", {30'd0, dbg_ptr}, 3);

    // wrap from ptr=3 to 0, then back-to-back skip to 1
    bus.ready = 1'b0; bus.req = 4'b0011;
    step(); expect_out("wrap", 1'b1, 2'd0, 4'b0001);
    bus.ready = 1'b1;
    step(); expect_out("skip", 1'b1, 2'd1, 4'b0010); chk("skip_ptr", {30'd0, dbg_ptr}, 1);
    bus.req = 4'b0000;
    step(); expect_out("drain", 1'b0, 2'd0, 4'b0000); chk("drain_ptr", {30'd0, dbg_ptr}, 2);

    // en gating
    bus.ready = 1'b0; bus.en = 1'b0; bus.req = 4'b1010;
    repeat (2) step();
    expect_out("en_off", 1'b0, 2'd0, 4'b0000);
    bus.en = 1'b1;
    step(); expect_out("en_on", 1'b1, 2'd3, 4'b1000);
    bus.en = 1'b0;
    repeat (3) step();
    expect_out("en_drop_hold", 1'b1, 2'd3, 4'b1000);
    bus.ready = 1'b1;
    step(); expect_out("en_drop_acc", 1'b0, 2'd0, 4'b0000); chk("en_drop_ptr", {30'd0, dbg_ptr}, 0);

    // reset in the middle of a hold
    bus.ready = 1'b0; bus.en = 1'b1; bus.req = 4'b1000;
    step(); expect_out("pre_rst", 1'b1, 2'd3, 4'b1000);
    reset_n = 1'b0;
    step(); expect_out("mid_rst", 1'b0, 2'd0, 4'b0000);
    chk("mid_rst_idx", {30'd0, bus.idx}, 0); chk("mid_rst_ptr", {30'd0, dbg_ptr}, 0);
    reset_n = 1'b1;
    step(); expect_out("post_rst", 1'b1, 2'd3, 4'b1000);

    // fairness: all requesting, consumer always ready
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; bus.req = 4'b1111; bus.en = 1'b1; bus.ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      expect_out("rr", 1'b1, W'(k % N), N'(1 << (k % N)));
    end

    // random tail, checked by the per-cycle model compare
    for (int c = 0; c < 300; c++) begin
      bus.req   = N'($urandom_range(0, (1 << N) - 1));
      bus.en    = ($urandom_range(0, 3) != 0);
      bus.ready = ($urandom_range(0, 2) != 0);
      reset_n   = ($urandom_range(0, 60) != 0);
      step();
    end

    reset_n = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
